// File: rtl/argmax.sv
// rtl/argmax.sv - sequential argmax over NUM_CLASSES signed scores, one class per cycle
module argmax #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int NUM_CLASSES = 10,
  localparam int IW          = $clog2(NUM_CLASSES)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          input_ready,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] values,
  output logic [IW-1:0]                 index,
  output logic signed [DATA_WIDTH-1:0]  max_value,
  output logic                          output_ready,
  output logic                          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCANNING,
    S_DONE
  } state_t;

  state_t                       r_state;
  state_t                       w_next_state;

  logic signed [DATA_WIDTH-1:0] r_captured [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] r_best_value;
  logic [IW-1:0]                r_best_index;
  logic [IW-1:0]                r_count;

  logic signed [DATA_WIDTH-1:0] w_values [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] w_candidate;
  logic                         w_capture;
  logic                         w_scanning;
  logic                         w_last;
  logic                         w_take;

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_unpack
    assign w_values[g] = values[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_candidate = r_captured[r_count];
  // Strict greater-than keeps the earliest index on ties.
  assign w_take      = w_candidate > r_best_value;
  assign w_last      = (r_count == IW'(NUM_CLASSES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_scanning   = 1'b0;
    output_ready = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (input_ready) begin
          w_capture    = 1'b1;
          w_next_state = S_SCANNING;
        end
      end
      S_SCANNING: begin
        busy       = 1'b1;
        w_scanning = 1'b1;
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        output_ready = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        r_captured[i] <= '0;
      end
      r_best_value <= '0;
      r_best_index <= '0;
      r_count      <= '0;
      index        <= '0;
      max_value    <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        r_captured[i] <= w_values[i];
      end
      r_best_value <= w_values[0];
      r_best_index <= '0;
      r_count      <= IW'(1);
    end else if (w_scanning) begin
      if (w_take) begin
        r_best_value <= w_candidate;
        r_best_index <= r_count;
      end
      // Publish on the final edge so the last comparison is included.
      if (w_last) begin
        r_count   <= '0;
        index     <= w_take ? r_count : r_best_index;
        max_value <= w_take ? w_candidate : r_best_value;
      end else begin
        r_count <= r_count + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_argmax.sv
// tb/tb_argmax.sv - self-checking bench for argmax against a whole-array reference model
module tb_argmax;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam int IW = 2;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 input_ready = 1'b0;
  logic [NC*DW-1:0]     values = '0;
  logic [IW-1:0]        index;
  logic signed [DW-1:0] max_value;
  logic                 output_ready;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] tv [NC];
  int                   exp_idx;
  logic signed [DW-1:0] exp_max;
  int                   last_idx = 0;
  logic signed [DW-1:0] last_max = '0;

  argmax #(.DATA_WIDTH(DW), .NUM_CLASSES(NC)) dut (
    .clock        (clock),
    .reset        (reset),
    .input_ready  (input_ready),
    .values       (values),
    .index        (index),
    .max_value    (max_value),
    .output_ready (output_ready),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic drive_values();
    for (int i = 0; i < NC; i++) values[i*DW +: DW] = tv[i];
  endtask

  // Largest value over the whole array, then the first position holding it.
  function automatic void set_expected();
    logic signed [DW-1:0] m;
    m = tv[0];
    for (int i = 1; i < NC; i++) if (tv[i] > m) m = tv[i];
    exp_max = m;
    exp_idx = 0;
    for (int i = NC - 1; i >= 0; i--) if (tv[i] == m) exp_idx = i;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clock);
    input_ready = 1'b1;
    @(negedge clock);
    checks++; if (index !== '0) begin errors++; $display("FAIL reset_index got %0d want 0", index); end
    checks++; if (max_value !== '0) begin errors++; $display("FAIL reset_max got %0d want 0", max_value); end
    checks++; if (output_ready !== 1'b0) begin errors++; $display("FAIL reset_pulse got %0b want 0", output_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    input_ready = 1'b0;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_directed();
    logic signed [DW-1:0] tbl [4][NC];
    tbl = '{'{3, -7, 12, 5}, '{5, 5, 5, 5}, '{-8, -3, -3, -9},
            '{32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh7fffffff}};
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NC; i++) tv[i] = tbl[t][i];
      set_expected();
      drive_values();
      input_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      input_ready = 1'b0;
      for (int j = 0; j <= NC; j++) begin
        checks++;
        if (output_ready !== (j == NC - 1)) begin
          errors++; $display("FAIL dir%0d_pulse_cyc%0d got %0b want %0b", t, j, output_ready, (j == NC - 1));
        end
        if (j == NC - 1) begin
          checks++; if (index !== IW'(exp_idx)) begin errors++; $display("FAIL dir%0d_index got %0d want %0d", t, index, exp_idx); end
          checks++; if (max_value !== exp_max) begin errors++; $display("FAIL dir%0d_max got %0d want %0d", t, max_value, exp_max); end
        end else if (j < NC - 1) begin
          checks++; if (index !== IW'(last_idx) || max_value !== last_max) begin
            errors++; $display("FAIL dir%0d_hold got %0d/%0d want %0d/%0d", t, index, max_value, last_idx, last_max);
          end
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dir%0d_busy got %0b want 1", t, busy); end
        end
        if (j != NC) @(negedge clock);
      end
      last_idx = exp_idx;
      last_max = exp_max;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NC; i++) begin
        case ($urandom_range(0, 2))
          0:       tv[i] = int'($urandom_range(0, 6)) - 3;
          1:       tv[i] = $urandom;
          default: tv[i] = ($urandom_range(0, 1) == 1) ? 32'sh7fffffff : 32'sh80000000;
        endcase
      end
      set_expected();
      drive_values();
      input_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      input_ready = 1'b0;
      for (int j = 0; j <= NC; j++) begin
        checks++;
        if (output_ready !== (j == NC - 1)) begin
          errors++; $display("FAIL rnd%0d_pulse_cyc%0d got %0b want %0b", t, j, output_ready, (j == NC - 1));
        end
        if (j == NC - 1) begin
          checks++; if (index !== IW'(exp_idx)) begin errors++; $display("FAIL rnd%0d_index got %0d want %0d", t, index, exp_idx); end
          checks++; if (max_value !== exp_max) begin errors++; $display("FAIL rnd%0d_max got %0d want %0d", t, max_value, exp_max); end
        end
        if (j != NC) @(negedge clock);
      end
      last_idx = exp_idx;
      last_max = exp_max;
    end
  endtask

  task automatic test_ignore_input();
    tv = '{1, 9, 2, 0};
    set_expected();
    drive_values();
    input_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    for (int j = 0; j <= 2 * NC; j++) begin
      checks++;
      if (output_ready !== (j == NC - 1)) begin
        errors++; $display("FAIL ign_pulse_cyc%0d got %0b want %0b", j, output_ready, (j == NC - 1));
      end
      if (j == NC - 1) begin
        checks++; if (index !== IW'(exp_idx)) begin errors++; $display("FAIL ign_index got %0d want %0d", index, exp_idx); end
        checks++; if (max_value !== exp_max) begin errors++; $display("FAIL ign_max got %0d want %0d", max_value, exp_max); end
      end
      if (j >= NC) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_cyc%0d got %0b want 0", j, busy); end
      end
      if (j < NC - 1) begin
        input_ready = 1'b1;
        values = {32'sd0, 32'sd0, 32'sd0, 32'sd50};
      end else begin
        input_ready = 1'b0;
      end
      if (j != 2 * NC) @(negedge clock);
    end
    last_idx = exp_idx;
    last_max = exp_max;
  endtask

  task automatic test_reset_midscan();
    tv = '{1, 9, 2, 0};
    drive_values();
    input_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    input_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %0b want 0", busy); end
    checks++; if (index !== '0) begin errors++; $display("FAIL rst_async_index got %0d want 0", index); end
    checks++; if (max_value !== '0) begin errors++; $display("FAIL rst_async_max got %0d want 0", max_value); end
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      checks++; if (output_ready !== 1'b0) begin errors++; $display("FAIL rst_pulse_cyc%0d got %0b want 0", j, output_ready); end
    end
    reset = 1'b0;
    last_idx = 0;
    last_max = '0;
    @(negedge clock);
    tv = '{0, 0, 4, 1};
    set_expected();
    drive_values();
    input_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    input_ready = 1'b0;
    for (int j = 0; j <= NC; j++) begin
      checks++;
      if (output_ready !== (j == NC - 1)) begin
        errors++; $display("FAIL post_rst_pulse_cyc%0d got %0b want %0b", j, output_ready, (j == NC - 1));
      end
      if (j == NC - 1) begin
        checks++; if (index !== IW'(exp_idx)) begin errors++; $display("FAIL post_rst_index got %0d want %0d", index, exp_idx); end
        checks++; if (max_value !== exp_max) begin errors++; $display("FAIL post_rst_max got %0d want %0d", max_value, exp_max); end
      end else if (j < NC - 1) begin
        checks++; if (index !== '0 || max_value !== '0) begin
          errors++; $display("FAIL post_rst_hold got %0d/%0d want 0/0", index, max_value);
        end
      end
      if (j != NC) @(negedge clock);
    end
    last_idx = exp_idx;
    last_max = exp_max;
  endtask

  task automatic test_back_to_back();
    logic signed [DW-1:0] bb [3][NC];
    int pulses;
    int last_pulse;
    pulses = 0;
    last_pulse = -1;
    for (int s = 0; s < 3; s++) for (int i = 0; i < NC; i++) bb[s][i] = $urandom;
    for (int c = 0; c < 16; c++) begin
      if (c <= 10) begin
        for (int i = 0; i < NC; i++) tv[i] = bb[c / 5][i];
        drive_values();
        input_ready = 1'b1;
      end else begin
        input_ready = 1'b0;
      end
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (output_ready !== (c % 5 == 3)) begin
        errors++; $display("FAIL b2b_pulse_cyc%0d got %0b want %0b", c, output_ready, (c % 5 == 3));
      end
      if (output_ready === 1'b1) begin
        if (last_pulse >= 0) begin
          checks++; if (c - last_pulse !== NC + 1) begin
            errors++; $display("FAIL b2b_spacing got %0d want %0d", c - last_pulse, NC + 1);
          end
        end
        last_pulse = c;
        pulses++;
      end
      if (c % 5 == 3) begin
        for (int i = 0; i < NC; i++) tv[i] = bb[c / 5][i];
        set_expected();
        checks++; if (index !== IW'(exp_idx)) begin errors++; $display("FAIL b2b%0d_index got %0d want %0d", c / 5, index, exp_idx); end
        checks++; if (max_value !== exp_max) begin errors++; $display("FAIL b2b%0d_max got %0d want %0d", c / 5, max_value, exp_max); end
      end
    end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulse_count got %0d want 3", pulses); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_input();
    test_reset_midscan();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/argmax.md
ARGMAX -- requirements
Module: argmax

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each signed class score.
REQ-002 Parameter NUM_CLASSES, default 10, number of scores compared; legal range NUM_CLASSES >= 2.
REQ-003 Derived width IW = $clog2(NUM_CLASSES), width of the index output.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 input_ready  input  1  scores valid this cycle; driven by the output_ready of the upstream neuron layer.
REQ-007 values  input  NUM_CLASSES x DATA_WIDTH signed  per-class scores, one per upstream neuron output.
REQ-008 index  output  IW  class number of the largest score from the last completed scan.
REQ-009 max_value  output  DATA_WIDTH signed  largest score from the last completed scan.
REQ-010 output_ready  output  1  single-cycle pulse marking a new valid index/max_value.
REQ-011 busy  output  1  high while a scan is in progress (state != IDLE).

Function
REQ-012 FSM states SHALL be IDLE, SCANNING and DONE.
REQ-013 IDLE: on a rising edge with input_ready=1, all NUM_CLASSES values SHALL be captured into an internal register array, best_value<=values[0], best_index<=0, count<=1, next state SCANNING.
REQ-014 IDLE with input_ready=0 SHALL remain in IDLE with all registers held.
REQ-015 SCANNING: each rising edge SHALL compare captured[count] against best_value as signed DATA_WIDTH values and update best_value/best_index only when strictly greater.
REQ-016 SCANNING: count SHALL increment by 1 per edge; on the edge that processes count==NUM_CLASSES-1, the state SHALL go to DONE.
REQ-017 On that same edge, index and max_value SHALL be loaded with the final best_index/best_value, including the last comparison.
REQ-018 DONE: output_ready SHALL be 1 for exactly one cycle; next state IDLE unconditionally.
REQ-019 Latency: if input_ready is sampled at edge k, output_ready SHALL be high from edge k+NUM_CLASSES-1 to edge k+NUM_CLASSES.
REQ-020 Ties SHALL resolve to the lowest index, a consequence of the strict greater-than comparison.
REQ-021 index and max_value SHALL change only at scan completion and hold their value until the next completion.
REQ-022 input_ready SHALL be ignored in SCANNING and DONE: no restart and no recapture. Scores SHALL be taken only from the capture made in IDLE, so changes on values after capture have no effect.
REQ-023 A new input_ready sampled in the cycle after DONE (state IDLE) SHALL start a new scan, giving a back-to-back throughput of one result per NUM_CLASSES+1 cycles.
REQ-024 busy SHALL be combinational from state: 1 in SCANNING and DONE, 0 in IDLE.
REQ-025 No arithmetic widening is required; comparison SHALL be full-width signed, with -2^(DATA_WIDTH-1) handled correctly.

Reset
REQ-026 While reset=1, regardless of clock, state SHALL be IDLE; index=0, max_value=0, output_ready=0, busy=0, count=0, best registers=0, capture array=0.
REQ-027 Reset asserted mid-scan SHALL abort the scan with no output_ready pulse. index/max_value SHALL read 0 afterwards, not a partial result.
REQ-028 The first input_ready sampled after reset deasserts SHALL start a normal scan.

Verification (NUM_CLASSES=4, DATA_WIDTH=32)
REQ-029 values={3,-7,12,5}, input_ready pulse at edge k -> output_ready high only at edge k+3, index=2, max_value=12.
REQ-030 values={5,5,5,5} -> index=0, max_value=5; values={-8,-3,-3,-9} -> index=1, max_value=-3.
REQ-031 values={-2^31,-2^31,-2^31,2^31-1} -> index=3, max_value=2^31-1; the boundary case at the last index and at the most-negative value.
REQ-032 Scan {1,9,2,0} started; during SCANNING assert input_ready and change values to {50,0,0,0} -> result index=1, max_value=9, single output_ready pulse, no second scan.
REQ-033 Scan {1,9,2,0} started; assert reset at edge k+1 -> no output_ready, index=0, max_value=0, busy=0. A following scan of {0,0,4,1} -> index=2, max_value=4.
REQ-034 Back-to-back: input_ready on the first IDLE cycle after each DONE for 3 scans -> 3 pulses spaced 5 cycles apart, each with the correct result.
